wb_stage: RTL and testbench

//  MEM/WB pipeline register and writeback formatter of the pipelined core.
//  - Captures the MEM-stage result and selects the writeback source: ALU result, load data or PC+4.
//  - Aligns and sign/zero-extends load data.
//  - Drives rd_addr / rd_data / write_en into the register file, which forwards same-cycle writes to its read ports.

---
 rtl/pesurv_pkg.sv | 14 +
 rtl/wb_load_align.sv | 43 ++++
 rtl/wb_stage.sv | 108 ++++++++++
 tb/tb_wb_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pesurv_pkg.sv
// Shared pipeline constants: writeback source selects, load sizes and the default datapath width.
package pesurv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

endpackage

// File: rtl/wb_load_align.sv
// Load extractor: picks the byte/half/word at the offset, extends it, flags misalignment.
// Purely combinational (0 cycles); no handshake, so no backpressure.
module wb_load_align
   import pesurv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] i_word,
   input  logic [1:0]      i_off,
   input  logic [1:0]      i_size,
   input  logic            i_unsigned,
   output logic [XLEN-1:0] o_data,
   output logic            o_misalign
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v     = i_word[7:0];
      half_v     = i_off[1] ? i_word[31:16] : i_word[15:0];
      o_data     = i_word;
      o_misalign = 1'b0;

      case (i_off)
         2'd1:    byte_v = i_word[15:8];
         2'd2:    byte_v = i_word[23:16];
         2'd3:    byte_v = i_word[31:24];
         default: byte_v = i_word[7:0];
      endcase

      // Size 11 falls into the word branch along with LS_WORD.
      case (i_size)
         LS_BYTE: o_data = {{(XLEN-8){~i_unsigned & byte_v[7]}}, byte_v};
         LS_HALF: begin
            o_data     = {{(XLEN-16){~i_unsigned & half_v[15]}}, half_v};
            o_misalign = i_off[0];
         end
         default: o_misalign = (i_off != 2'b00);
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register and writeback formatter; 1-cycle input->regfile write, outputs only from stage flops.
// Holds on i_stall, bubbles on i_flush (flush wins); optional retire counter under WB_RETIRE_CNT_EN.
module wb_stage
   import pesurv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic             i_reg_write,
   input  logic [4:0]       i_rd_addr,
   input  logic [1:0]       i_wb_sel,
   input  logic [XLEN-1:0]  i_alu_result,
   input  logic [XLEN-1:0]  i_pc_plus4,
   input  logic [XLEN-1:0]  i_load_data,
   input  logic [1:0]       i_load_size,
   input  logic             i_load_unsigned,
   output logic [4:0]       o_rd_addr,
   output logic [XLEN-1:0]  o_rd_data,
   output logic             o_write_en,
   output logic             o_load_misalign,
   output logic [CNT_W-1:0] o_instret
);

   typedef struct packed {
      logic            vld;
      logic            reg_write;
      logic [4:0]      rd_addr;
      logic [1:0]      wb_sel;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] load_data;
      logic [1:0]      load_size;
      logic            load_unsigned;
   } stage_t;

   stage_t          stage_q, stage_d;
   logic [XLEN-1:0] load_val;
   logic            align_mis;
   logic            misalign;

   always_comb begin
      stage_d = stage_q;
      if (i_flush) begin
         stage_d.vld = 1'b0;
      end else if (!i_stall) begin
         stage_d.vld           = i_valid;
         stage_d.reg_write     = i_reg_write;
         stage_d.rd_addr       = i_rd_addr;
         stage_d.wb_sel        = i_wb_sel;
         stage_d.alu_result    = i_alu_result;
         stage_d.pc_plus4      = i_pc_plus4;
         stage_d.load_data     = i_load_data;
         stage_d.load_size     = i_load_size;
         stage_d.load_unsigned = i_load_unsigned;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) stage_q <= '0;
      else          stage_q <= stage_d;
   end

   wb_load_align #(.XLEN(XLEN)) u_align (
      .i_word     (stage_q.load_data),
      .i_off      (stage_q.alu_result[1:0]),
      .i_size     (stage_q.load_size),
      .i_unsigned (stage_q.load_unsigned),
      .o_data     (load_val),
      .o_misalign (align_mis)
   );

   always_comb begin
      misalign = stage_q.vld & (stage_q.wb_sel == WB_SEL_LOAD) & align_mis;
      case (stage_q.wb_sel)
         WB_SEL_LOAD: o_rd_data = load_val;
         WB_SEL_PC4:  o_rd_data = stage_q.pc_plus4;
         default:     o_rd_data = stage_q.alu_result;
      endcase
      o_rd_addr       = stage_q.rd_addr;
      o_load_misalign = misalign;
      o_write_en      = stage_q.vld & stage_q.reg_write & (stage_q.rd_addr != 5'd0) & ~misalign;
   end

`ifdef WB_RETIRE_CNT_EN
   logic             retire;
   logic [CNT_W-1:0] instret_q, instret_d;

   always_comb begin
      retire    = stage_q.vld & ~i_stall & ~i_flush;
      instret_d = instret_q + CNT_W'(retire);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) instret_q <= '0;
      else          instret_q <= instret_d;
   end

   assign o_instret = instret_q;
`else
   assign o_instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Table-driven bench for wb_stage with an expected-result queue and a small retire-count model.
module tb_wb_stage;
   import pesurv_pkg::*;

`ifdef WB_RETIRE_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   localparam logic [31:0] LD = 32'h80FF7F01;

   typedef struct {
      logic        valid, stall, flush, reg_write;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] alu, pc4, ld;
      logic [1:0]  size;
      logic        uns;
   } in_t;

   typedef struct {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
      logic        chk_data;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   logic        clk, rst_n;
   logic        valid, stall, flush, reg_write, uns;
   logic [4:0]  rd;
   logic [1:0]  sel, size;
   logic [31:0] alu, pc4, ld;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic        o_write_en, o_load_misalign;
   logic [63:0] o_instret;

   int          n_cmp, n_fail;
   bit          mvld;
   logic [63:0] mcnt;
   exp_t        sb[$];
   vec_t        vt[20];

   wb_stage #(.XLEN(32), .CNT_W(64)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
      .i_reg_write(reg_write), .i_rd_addr(rd), .i_wb_sel(sel), .i_alu_result(alu),
      .i_pc_plus4(pc4), .i_load_data(ld), .i_load_size(size), .i_load_unsigned(uns),
      .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_write_en(o_write_en),
      .o_load_misalign(o_load_misalign), .o_instret(o_instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic v, input logic rw, input logic [4:0] r, input logic [1:0] s,
                               input logic [31:0] a, input logic [31:0] p, input logic [31:0] l,
                               input logic [1:0] sz, input logic u, input logic ew, input logic [4:0] er,
                               input logic [31:0] ed, input logic em);
      vec_t t;
      t.i = '{valid: v, stall: 1'b0, flush: 1'b0, reg_write: rw, rd: r, sel: s, alu: a, pc4: p,
              ld: l, size: sz, uns: u};
      t.e = '{wen: ew, rd: er, data: ed, mis: em, chk_data: 1'b1};
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input string name, input in_t v, input exp_t e);
      exp_t got;
      @(negedge clk);
      valid = v.valid; stall = v.stall; flush = v.flush; reg_write = v.reg_write;
      rd = v.rd; sel = v.sel; alu = v.alu; pc4 = v.pc4; ld = v.ld; size = v.size; uns = v.uns;
      sb.push_back(e);
      @(posedge clk);
      if (v.flush) mvld = 1'b0;
      else if (!v.stall) begin
         if (mvld && CNT_ON) mcnt++;
         mvld = v.valid;
      end
      #1;
      got = sb.pop_front();
      chk({name, ".wen"}, 64'(o_write_en), 64'(got.wen));
      chk({name, ".mis"}, 64'(o_load_misalign), 64'(got.mis));
      if (got.chk_data) begin
         chk({name, ".rd"}, 64'(o_rd_addr), 64'(got.rd));
         chk({name, ".data"}, 64'(o_rd_data), 64'(got.data));
      end
      chk({name, ".instret"}, o_instret, mcnt);
   endtask

   task automatic chk_zero(input string name);
      chk({name, ".wen"}, 64'(o_write_en), 64'd0);
      chk({name, ".rd"}, 64'(o_rd_addr), 64'd0);
      chk({name, ".data"}, 64'(o_rd_data), 64'd0);
      chk({name, ".mis"}, 64'(o_load_misalign), 64'd0);
      chk({name, ".instret"}, o_instret, 64'd0);
   endtask

   initial begin
      vec_t h;
      n_cmp = 0; n_fail = 0; mvld = 1'b0; mcnt = '0;
      rst_n = 1'b0; valid = 0; stall = 0; flush = 0; reg_write = 0; uns = 0;
      rd = '0; sel = '0; size = '0; alu = '0; pc4 = '0; ld = '0;

      vt[0]  = mk(1, 1, 5'd5,  WB_SEL_ALU,  32'h1234, 0, 0,  LS_WORD, 0, 1, 5'd5,  32'h00001234, 0);
      vt[1]  = mk(1, 1, 5'd0,  WB_SEL_ALU,  32'h1234, 0, 0,  LS_WORD, 0, 0, 5'd0,  32'h00001234, 0);
      vt[2]  = mk(1, 1, 5'd7,  WB_SEL_LOAD, 32'h1003, 0, LD, LS_BYTE, 0, 1, 5'd7,  32'hFFFFFF80, 0);
      vt[3]  = mk(1, 1, 5'd7,  WB_SEL_LOAD, 32'h1003, 0, LD, LS_BYTE, 1, 1, 5'd7,  32'h00000080, 0);
      vt[4]  = mk(1, 1, 5'd7,  WB_SEL_LOAD, 32'h1002, 0, LD, LS_HALF, 0, 1, 5'd7,  32'hFFFF80FF, 0);
      vt[5]  = mk(1, 1, 5'd7,  WB_SEL_LOAD, 32'h1002, 0, LD, LS_HALF, 1, 1, 5'd7,  32'h000080FF, 0);
      vt[6]  = mk(1, 1, 5'd2,  WB_SEL_LOAD, 32'h1000, 0, LD, LS_BYTE, 0, 1, 5'd2,  32'h00000001, 0);
      vt[7]  = mk(1, 1, 5'd2,  WB_SEL_LOAD, 32'h1001, 0, LD, LS_BYTE, 0, 1, 5'd2,  32'h0000007F, 0);
      vt[8]  = mk(1, 1, 5'd2,  WB_SEL_LOAD, 32'h1002, 0, LD, LS_BYTE, 0, 1, 5'd2,  32'hFFFFFFFF, 0);
      vt[9]  = mk(1, 1, 5'd2,  WB_SEL_LOAD, 32'h1002, 0, LD, LS_BYTE, 1, 1, 5'd2,  32'h000000FF, 0);
      vt[10] = mk(1, 1, 5'd3,  WB_SEL_LOAD, 32'h1000, 0, LD, LS_HALF, 0, 1, 5'd3,  32'h00007F01, 0);
      vt[11] = mk(1, 1, 5'd4,  WB_SEL_LOAD, 32'h1000, 0, LD, LS_WORD, 0, 1, 5'd4,  32'h80FF7F01, 0);
      vt[12] = mk(1, 1, 5'd8,  WB_SEL_LOAD, 32'h1002, 0, LD, LS_WORD, 0, 0, 5'd8,  32'h80FF7F01, 1);
      vt[13] = mk(1, 1, 5'd8,  WB_SEL_LOAD, 32'h1001, 0, LD, LS_HALF, 0, 0, 5'd8,  32'h00007F01, 1);
      vt[14] = mk(1, 1, 5'd8,  WB_SEL_LOAD, 32'h1003, 0, LD, LS_HALF, 0, 0, 5'd8,  32'hFFFF80FF, 1);
      vt[15] = mk(1, 1, 5'd9,  WB_SEL_LOAD, 32'h1000, 0, LD, 2'b11,   0, 1, 5'd9,  32'h80FF7F01, 0);
      vt[16] = mk(1, 1, 5'd1,  WB_SEL_PC4,  32'h1000, 32'h104, LD, LS_WORD, 0, 1, 5'd1, 32'h00000104, 0);
      vt[17] = mk(1, 1, 5'd1,  2'b11,       32'hDEAD, 32'h104, LD, LS_WORD, 0, 1, 5'd1, 32'h0000DEAD, 0);
      vt[18] = mk(0, 1, 5'd8,  WB_SEL_LOAD, 32'h1002, 0, LD, LS_WORD, 0, 0, 5'd8,  32'h80FF7F01, 0);
      vt[19] = mk(1, 0, 5'd6,  WB_SEL_ALU,  32'h77,   0, 0,  LS_WORD, 0, 0, 5'd6,  32'h00000077, 0);

      #3;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) step($sformatf("v%0d", i), vt[i].i, vt[i].e);

      // JAL held for three stall cycles, then released behind a bubble.
      h = mk(0, 0, 5'd0, WB_SEL_ALU, 0, 0, 0, LS_WORD, 0, 0, 5'd0, 32'h0, 0);
      step("drain", h.i, h.e);
      h = mk(1, 1, 5'd1, WB_SEL_PC4, 32'h40, 32'h104, 0, LS_WORD, 0, 1, 5'd1, 32'h104, 0);
      step("jal", h.i, h.e);
      for (int k = 0; k < 3; k++) begin
         h = mk(1, 1, 5'd9, WB_SEL_ALU, 32'hBAD, 32'hBAD, 0, LS_WORD, 0, 1, 5'd1, 32'h104, 0);
         h.i.stall = 1'b1;
         step($sformatf("jal_stall%0d", k), h.i, h.e);
      end
      h = mk(0, 0, 5'd0, WB_SEL_ALU, 0, 0, 0, LS_WORD, 0, 0, 5'd0, 32'h0, 0);
      step("jal_release", h.i, h.e);

      // Flush and stall together on a valid entry: bubble, no retire.
      h = mk(1, 1, 5'd3, WB_SEL_ALU, 32'h55, 0, 0, LS_WORD, 0, 1, 5'd3, 32'h55, 0);
      step("fs_load", h.i, h.e);
      h = mk(1, 1, 5'd4, WB_SEL_ALU, 32'h66, 0, 0, LS_WORD, 0, 0, 5'd0, 32'h0, 0);
      h.i.stall = 1'b1; h.i.flush = 1'b1; h.e.chk_data = 1'b0;
      step("fs_both", h.i, h.e);

      // Asynchronous reset with a valid writing entry in the stage.
      h = mk(1, 1, 5'd5, WB_SEL_ALU, 32'h1234, 0, 0, LS_WORD, 0, 1, 5'd5, 32'h1234, 0);
      step("arst_load", h.i, h.e);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("arst");
      mvld = 1'b0; mcnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      h = mk(1, 1, 5'd5, WB_SEL_ALU, 32'h1234, 0, 0, LS_WORD, 0, 1, 5'd5, 32'h1234, 0);
      step("post_arst", h.i, h.e);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
